// File: rtl/overlay_pkg.sv
// Shared types and defaults for the overlay SDRAM fetch scheduler.
package overlay_pkg;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ENTRY_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } pixel_t;

endpackage

// File: rtl/overlay_fetch_sched_if.sv
// SDRAM channel request/acknowledge bundle between the scheduler and the memory port.
interface overlay_fetch_sched_if #(
    parameter int unsigned ADDR_W = overlay_pkg::DEF_ADDR_W
);
    logic                               mem_req;
    logic                               mem_rnw;
    logic [ADDR_W-1:0]                  mem_addr;
    logic [overlay_pkg::WORD_W-1:0]     mem_din;
    logic                               mem_ack;
    logic [overlay_pkg::ENTRY_W-1:0]    mem_dout;

    modport master (output mem_req, mem_rnw, mem_addr, mem_din, input mem_ack, mem_dout);
    modport slave  (input mem_req, mem_rnw, mem_addr, mem_din, output mem_ack, mem_dout);
endinterface

// File: rtl/overlay_prefetch_fifo.sv
// Prefetch FIFO: flop storage, synchronous flush, head read straight from the storage flops.
module overlay_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/overlay_fetch_sched.sv
// Overlay SDRAM channel sequencer: paired-byte download writes plus read-ahead pixel prefetch.
module overlay_fetch_sched
    import overlay_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  rom_dl,
    input  logic                  bg_dl,
    input  logic                  dl_wr,
    input  logic [24:0]           dl_addr,
    input  logic [7:0]            dl_data,
    input  logic                  sdram_present,
    input  logic                  ce_pix,
    input  logic                  de,
    input  logic                  vs,
    overlay_fetch_sched_if.master mem,
    output pixel_t                pix,
    output logic                  overlay_valid,
    output logic                  underflow
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t              state, state_next;
    logic                vs_d, bg_dl_d, flush, bg_rise, bg_fall, prefetch_en;
    logic [7:0]          even_byte;
    logic                wr_pend, odd_wr;
    logic [ADDR_W-1:0]   wr_addr, pend_addr, fetch_ptr;
    logic [WORD_W-1:0]   wr_data, pend_data;
    logic                drop, half, rd_room;
    logic                wr_go, rd_go, ack_wr, ack_rd;
    logic                pop_cycle, fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_head;

    assign flush       = vs && !vs_d;
    assign bg_rise     = bg_dl && !bg_dl_d;
    assign bg_fall     = !bg_dl && bg_dl_d;
    assign prefetch_en = overlay_valid && !bg_dl;
    assign odd_wr      = dl_wr && bg_dl && dl_addr[0];
    // An odd byte arriving in IDLE is issued directly, without waiting a cycle in the pending slot.
    assign pend_addr   = odd_wr ? ADDR_W'(dl_addr[24:1]) : wr_addr;
    assign pend_data   = odd_wr ? {dl_data, even_byte} : wr_data;
    assign rd_room     = (32'(fifo_count) + 32'(state == RD)) < 32'(FIFO_DEPTH);
    assign pop_cycle   = ce_pix && de && prefetch_en && !flush;
    assign fifo_pop    = pop_cycle && !fifo_empty && half;
    assign fifo_push   = ack_rd && !drop && !bg_rise && !fifo_full;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_go      = 1'b0;
        rd_go      = 1'b0;
        ack_wr     = 1'b0;
        ack_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend || odd_wr) begin
                    state_next = WR;
                    wr_go      = 1'b1;
                end else if (prefetch_en && rd_room && !flush) begin
                    state_next = RD;
                    rd_go      = 1'b1;
                end
            end
            WR: if (mem.mem_ack) begin
                state_next = IDLE;
                ack_wr     = 1'b1;
            end
            RD: if (mem.mem_ack) begin
                state_next = IDLE;
                ack_rd     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request bus: loaded on issue, held until the ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem.mem_req  <= 1'b0;
            mem.mem_rnw  <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
        end else if (wr_go) begin
            mem.mem_req  <= 1'b1;
            mem.mem_rnw  <= 1'b0;
            mem.mem_addr <= pend_addr;
            mem.mem_din  <= pend_data;
        end else if (rd_go) begin
            mem.mem_req  <= 1'b1;
            mem.mem_rnw  <= 1'b1;
            mem.mem_addr <= fetch_ptr;
        end else if (ack_wr || ack_rd) begin
            mem.mem_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vs_d          <= 1'b0;
            bg_dl_d       <= 1'b0;
            even_byte     <= '0;
            wr_pend       <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            overlay_valid <= 1'b0;
            fetch_ptr     <= '0;
            drop          <= 1'b0;
        end else begin
            vs_d    <= vs;
            bg_dl_d <= bg_dl;
            if (dl_wr && bg_dl && !dl_addr[0]) even_byte <= dl_data;
            if (odd_wr) begin
                wr_pend <= 1'b1;
                wr_addr <= pend_addr;
                wr_data <= pend_data;
            end else if (ack_wr) begin
                wr_pend <= 1'b0;
            end
            if (rom_dl)                        overlay_valid <= 1'b0;
            else if (bg_fall && sdram_present) overlay_valid <= 1'b1;
            if (flush)      fetch_ptr <= '0;
            else if (rd_go) fetch_ptr <= fetch_ptr + ADDR_W'(2);
            // A read in flight is never abandoned; its data is just discarded on the ack.
            if (ack_rd)                                drop <= 1'b0;
            else if (state == RD && (flush || bg_rise)) drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pix       <= '0;
            half      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!prefetch_en)   pix <= '0;
            else if (pop_cycle) pix <= fifo_empty ? pixel_t'(16'h0)
                                      : (half ? pixel_t'(fifo_head[31:16]) : pixel_t'(fifo_head[15:0]));
            if (flush)                          half <= 1'b0;
            else if (pop_cycle && !fifo_empty)  half <= !half;
            if (flush)                                             underflow <= 1'b0;
            else if ((pop_cycle && fifo_empty) || (odd_wr && wr_pend)) underflow <= 1'b1;
        end
    end

    overlay_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (mem.mem_dout),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
endmodule

// File: tb/tb_overlay_fetch_sched.sv
// Scoreboard bench for overlay_fetch_sched: expected requests and pixels queued at stimulus time.
module tb_overlay_fetch_sched;

    typedef struct packed {
        logic        rnw;
        logic [23:0] addr;
        logic [15:0] din;
    } req_t;

    logic               clk_sys = 1'b0;
    logic               reset_n = 1'b0;
    logic               rom_dl = 1'b0, bg_dl = 1'b0, dl_wr = 1'b0;
    logic [24:0]        dl_addr = '0;
    logic [7:0]         dl_data = '0;
    logic               sdram_present = 1'b0, ce_pix = 1'b0, de = 1'b0, vs = 1'b0;
    overlay_pkg::pixel_t pix;
    logic               overlay_valid, underflow;

    req_t        exp_q[$];
    logic [15:0] pix_q[$];
    logic [23:0] last_addr = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    overlay_fetch_sched_if #(.ADDR_W(24)) mem_bus ();

    overlay_fetch_sched dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .rom_dl        (rom_dl),
        .bg_dl         (bg_dl),
        .dl_wr         (dl_wr),
        .dl_addr       (dl_addr),
        .dl_data       (dl_data),
        .sdram_present (sdram_present),
        .ce_pix        (ce_pix),
        .de            (de),
        .vs            (vs),
        .mem           (mem_bus),
        .pix           (pix),
        .overlay_valid (overlay_valid),
        .underflow     (underflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pop_pix(input string tag);
        logic [15:0] e;
        e = pix_q.pop_front();
        check(tag, 64'(pix), 64'(e));
    endtask

    task automatic do_pop(input string tag, input logic [15:0] e);
        pix_q.push_back(e);
        ce_pix = 1'b1;
        de     = 1'b1;
        tick();
        pop_pix(tag);
        ce_pix = 1'b0;
        de     = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        req_t e;
        int   n = 0;
        while (!mem_bus.mem_req && n < 40) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        last_addr = e.addr;
        check({tag, "_req"}, 64'(mem_bus.mem_req), 64'd1);
        check({tag, "_rnw"}, 64'(mem_bus.mem_rnw), 64'(e.rnw));
        check({tag, "_addr"}, 64'(mem_bus.mem_addr), 64'(e.addr));
        if (!e.rnw) check({tag, "_din"}, 64'(mem_bus.mem_din), 64'(e.din));
    endtask

    task automatic ack_req(input string tag, input logic [31:0] data);
        tick();
        tick();
        check({tag, "_hold"}, 64'({mem_bus.mem_req, mem_bus.mem_addr}), 64'({1'b1, last_addr}));
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_dout = data;
        tick();
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_dout = '0;
        check({tag, "_done"}, 64'(mem_bus.mem_req), 64'd0);
    endtask

    initial begin
        logic [31:0] fill_data [4];
        logic [15:0] stream    [10];
        fill_data = '{32'hBBBBAAAA, 32'h22221111, 32'h44443333, 32'h66665555};
        stream    = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                      16'h6666, 16'h7777, 16'h8888, 16'h0000, 16'h0000};
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_dout = '0;

        repeat (3) tick();
        check("rst_req", 64'(mem_bus.mem_req), 64'd0);
        check("rst_pix", 64'(pix), 64'd0);
        check("rst_valid", 64'(overlay_valid), 64'd0);
        check("rst_uf", 64'(underflow), 64'd0);
        reset_n = 1'b1;
        sdram_present = 1'b1;
        tick();

        // Byte pairing into one word write
        bg_dl = 1'b1;
        tick();
        dl_wr = 1'b1; dl_addr = 25'd0; dl_data = 8'h34;
        tick();
        dl_addr = 25'd1; dl_data = 8'h12;
        exp_q.push_back('{rnw: 1'b0, addr: 24'd0, din: 16'h1234});
        tick();
        dl_wr = 1'b0;
        check("wr_latency", 64'(mem_bus.mem_req), 64'd1);
        wait_req("wr0");
        ack_req("wr0", 32'h0);
        bg_dl = 1'b0;
        tick();
        check("valid_set", 64'(overlay_valid), 64'd1);

        // Prefetch fills the FIFO, then holds off
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rnw: 1'b1, addr: 24'(2 * i), din: 16'h0});
            wait_req($sformatf("fill%0d", i));
            ack_req($sformatf("fill%0d", i), fill_data[i]);
        end
        repeat (5) tick();
        check("full_hold", 64'(mem_bus.mem_req), 64'd0);

        // Pixel stream from the head entry, then refill of the freed slot
        do_pop("pix_lo", 16'hAAAA);
        do_pop("pix_hi", 16'hBBBB);
        exp_q.push_back('{rnw: 1'b1, addr: 24'd8, din: 16'h0});
        wait_req("refill");
        ack_req("refill", 32'h88887777);

        // Drain with the next read withheld until underflow
        exp_q.push_back('{rnw: 1'b1, addr: 24'd10, din: 16'h0});
        ce_pix = 1'b1;
        de     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pix_q.push_back(stream[i]);
            tick();
            pop_pix($sformatf("drain%0d", i));
        end
        ce_pix = 1'b0;
        de     = 1'b0;
        check("uf_set", 64'(underflow), 64'd1);

        // Flush while a read is in flight
        wait_req("rd10");
        vs = 1'b1;
        tick();
        check("uf_clear", 64'(underflow), 64'd0);
        ack_req("rd10", 32'hDEADBEEF);
        vs = 1'b0;
        exp_q.push_back('{rnw: 1'b1, addr: 24'd0, din: 16'h0});
        wait_req("post_flush");
        ack_req("post_flush", 32'h56781234);
        do_pop("flush_pix", 16'h1234);

        // Download posted during a read: write goes before the next read
        exp_q.push_back('{rnw: 1'b1, addr: 24'd2, din: 16'h0});
        wait_req("rd2");
        bg_dl = 1'b1;
        tick();
        check("bg_pix", 64'(pix), 64'd0);
        dl_wr = 1'b1; dl_addr = 25'h100; dl_data = 8'hCD;
        tick();
        dl_addr = 25'h101; dl_data = 8'hAB;
        tick();
        dl_wr = 1'b0;
        bg_dl = 1'b0;
        tick();
        check("rd_busy", 64'({mem_bus.mem_req, mem_bus.mem_rnw}), 64'd3);
        ack_req("rd2", 32'h11110000);
        exp_q.push_back('{rnw: 1'b0, addr: 24'h80, din: 16'hABCD});
        exp_q.push_back('{rnw: 1'b1, addr: 24'd4, din: 16'h0});
        wait_req("wr1");
        ack_req("wr1", 32'h0);
        wait_req("rd4");
        ack_req("rd4", 32'h4444CCCC);
        do_pop("prio_hi", 16'h5678);
        do_pop("prio_lo", 16'hCCCC);

        // Cartridge download clears the overlay and stops prefetch
        exp_q.push_back('{rnw: 1'b1, addr: 24'd6, din: 16'h0});
        rom_dl = 1'b1;
        tick();
        tick();
        rom_dl = 1'b0;
        check("rom_valid", 64'(overlay_valid), 64'd0);
        check("rom_pix", 64'(pix), 64'd0);
        wait_req("rd6");
        ack_req("rd6", 32'h0);
        repeat (6) tick();
        check("stop_req", 64'(mem_bus.mem_req), 64'd0);
        check("uf_final", 64'(underflow), 64'd0);
        check("exp_left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
